// File: rtl/freq_bins_rmw.sv
// rtl/freq_bins_rmw.sv - multi-channel saturating read-modify-write bin store with clear sequencer
module freq_bins_rmw #(
  parameter int data_w = 20,
  parameter int addr_w = 7,
  parameter int ch_w   = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  input  logic              upd_valid,
  input  logic              upd_mode,
  input  logic [ch_w-1:0]   upd_ch,
  input  logic [addr_w-1:0] upd_addr,
  input  logic [data_w-1:0] upd_delta,
  output logic              ovf,
  input  logic              r_en,
  input  logic [ch_w-1:0]   r_ch,
  input  logic [addr_w-1:0] r_addr,
  output logic [data_w-1:0] d_out,
  output logic              r_valid
);
  localparam int n_ch  = 2 ** ch_w;
  localparam int depth = 2 ** addr_w;
  localparam logic [addr_w-1:0] k_one = addr_w'(1);
  localparam logic [addr_w-1:0] k_max = '1;
  localparam logic [data_w-1:0] val_max = {1'b0, {(data_w-1){1'b1}}};
  localparam logic [data_w-1:0] val_min = {1'b1, {(data_w-1){1'b0}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            st_q;
  logic [addr_w-1:0] k_q;
  logic [data_w-1:0] mem_q [n_ch][depth];

  logic              s1_vld_q;
  logic              s1_mode_q;
  logic [ch_w-1:0]   s1_ch_q;
  logic [addr_w-1:0] s1_addr_q;
  logic [data_w-1:0] s1_delta_q;
  logic [data_w-1:0] s1_old_q;

  logic [data_w-1:0] d_out_q;
  logic              r_valid_q;

  logic [data_w:0]   sum_d;
  logic [data_w-1:0] s1_new_d;
  logic              s1_sat_d;
  logic [data_w-1:0] s0_old_d;
  logic              fwd_d;
  logic              upd_acc;
  logic              rd_acc;
  logic              wr_en;

  // Reset overrides the sequencer so requests are refused the same cycle reset is seen.
  assign busy    = reset | (st_q == ST_CLEAR);
  assign upd_acc = upd_valid & ~busy;
  assign rd_acc  = r_en & ~busy;
  // A write whose commit edge coincides with reset is discarded.
  assign wr_en   = s1_vld_q & ~reset;
  assign ovf     = wr_en & s1_sat_d;
  assign d_out   = d_out_q;
  assign r_valid = r_valid_q;

  // One extra sign bit so the accumulate can never wrap before clamping.
  assign sum_d = {s1_old_q[data_w-1], s1_old_q} + {s1_delta_q[data_w-1], s1_delta_q};

  // S1: produce the value to write and flag clamping (accumulate only).
  always_comb begin
    s1_sat_d = 1'b0;
    s1_new_d = s1_delta_q;
    if (!s1_mode_q) begin
      if (sum_d[data_w] != sum_d[data_w-1]) begin
        s1_sat_d = 1'b1;
        s1_new_d = sum_d[data_w] ? val_min : val_max;
      end else begin
        s1_new_d = sum_d[data_w-1:0];
      end
    end
  end

  // S0: old value comes from S1's result when both target the same bin, else memory.
  always_comb begin
    fwd_d    = s1_vld_q && (s1_ch_q == upd_ch) && (s1_addr_q == upd_addr);
    s0_old_d = fwd_d ? s1_new_d : mem_q[upd_ch][upd_addr];
  end

  // Clear sequencer: sweep k across all channels after reset, then run forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_CLEAR;
      k_q  <= '0;
    end else begin
      case (st_q)
        ST_CLEAR: begin
          k_q <= k_q + k_one;
          if (k_q == k_max) st_q <= ST_RUN;
        end
        default: st_q <= ST_RUN;
      endcase
    end
  end

  // Bin storage: zeroing sweep while clearing, otherwise the S1 commit.
  always_ff @(posedge clk) begin
    if (!reset && st_q == ST_CLEAR) begin
      for (int c = 0; c < n_ch; c++) mem_q[c[ch_w-1:0]][k_q] <= '0;
    end else if (wr_en) begin
      mem_q[s1_ch_q][s1_addr_q] <= s1_new_d;
    end
  end

  // Update pipeline register between S0 and S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_ch_q    <= '0;
      s1_addr_q  <= '0;
      s1_delta_q <= '0;
      s1_old_q   <= '0;
    end else begin
      s1_vld_q <= upd_acc;
      if (upd_acc) begin
        s1_mode_q  <= upd_mode;
        s1_ch_q    <= upd_ch;
        s1_addr_q  <= upd_addr;
        s1_delta_q <= upd_delta;
        s1_old_q   <= s0_old_d;
      end
    end
  end

  // Read port: one-cycle latency, sees memory before any same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_acc;
      if (rd_acc) d_out_q <= mem_q[r_ch][r_addr];
    end
  end

endmodule

// File: tb/tb_freq_bins_rmw.sv
// tb/tb_freq_bins_rmw.sv - scoreboard bench for freq_bins_rmw against a bin-array reference model
module tb_freq_bins_rmw;
  localparam int DW = 20;
  localparam int AW = 7;
  localparam int CW = 1;
  localparam int NCH = 2;
  localparam int DEPTH = 128;
  localparam int VMAX = 524287;
  localparam int VMIN = -524288;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy;
  logic          upd_valid = 1'b0;
  logic          upd_mode = 1'b0;
  logic [CW-1:0] upd_ch = '0;
  logic [AW-1:0] upd_addr = '0;
  logic [DW-1:0] upd_delta = '0;
  logic          ovf;
  logic          r_en = 1'b0;
  logic [CW-1:0] r_ch = '0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] d_out;
  logic          r_valid;

  always #5 clk = ~clk;

  freq_bins_rmw #(.data_w(DW), .addr_w(AW), .ch_w(CW)) dut (
    .clk(clk), .reset(reset), .busy(busy),
    .upd_valid(upd_valid), .upd_mode(upd_mode), .upd_ch(upd_ch),
    .upd_addr(upd_addr), .upd_delta(upd_delta), .ovf(ovf),
    .r_en(r_en), .r_ch(r_ch), .r_addr(r_addr),
    .d_out(d_out), .r_valid(r_valid)
  );

  typedef struct {
    bit busy;
    bit ovf;
    bit rv;
    int dout;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 0;

  // Reference model: bin contents plus the single update still in flight.
  int model[NCH][DEPTH];
  int clr_left = 0;
  bit pend_v = 0;
  bit pend_m = 0;
  int pend_ch = 0, pend_a = 0, pend_d = 0;
  bit nxt_rv = 0;
  int nxt_dout = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides what the DUT must show this cycle.
  task automatic cyc(input bit rst, input bit uv, input bit um, input int uch, input int ua,
                     input int ud, input bit re, input int rch, input int ra);
    exp_t e;
    bit   rd_acc;
    int   rd_val;
    int   v;
    reset     = rst;
    upd_valid = uv;
    upd_mode  = um;
    upd_ch    = uch[CW-1:0];
    upd_addr  = ua[AW-1:0];
    upd_delta = ud[DW-1:0];
    r_en      = re;
    r_ch      = rch[CW-1:0];
    r_addr    = ra[AW-1:0];
    e.rv   = nxt_rv;
    e.dout = nxt_dout;
    e.ovf  = 0;
    e.busy = rst || (clr_left > 0);
    rd_acc = 0;
    rd_val = 0;
    if (rst) begin
      pend_v   = 0;
      clr_left = DEPTH;
      for (int c = 0; c < NCH; c++)
        for (int a = 0; a < DEPTH; a++) model[c][a] = 0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (re) begin
        rd_acc = 1;
        rd_val = model[rch][ra];
      end
      if (pend_v) begin
        if (pend_m) v = pend_d;
        else v = model[pend_ch][pend_a] + pend_d;
        if (v > VMAX) begin v = VMAX; e.ovf = 1; end
        if (v < VMIN) begin v = VMIN; e.ovf = 1; end
        model[pend_ch][pend_a] = v;
      end
      pend_v = uv; pend_m = um; pend_ch = uch; pend_a = ua; pend_d = ud;
    end
    if (rst) begin
      nxt_rv = 0;
      nxt_dout = 0;
    end else begin
      nxt_rv = rd_acc;
      if (rd_acc) nxt_dout = rd_val;
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input bit um, input int ch, input int a, input int d);
    cyc(0, 1, um, ch, a, d, 0, 0, 0);
  endtask

  task automatic rd(input int ch, input int a);
    cyc(0, 0, 0, 0, 0, 0, 1, ch, a);
  endtask

  // Random requests, including during busy where they must be dropped.
  task automatic junk(input bit rst, input int n);
    for (int i = 0; i < n; i++)
      cyc(rst, 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
          int'($urandom_range(0, 1000)), 1'($urandom), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 127)));
  endtask

  // Monitor: every cycle, pop the expectation and compare against what the DUT shows.
  initial begin
    exp_t e;
    int   got;
    while (!done) begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("busy", int'(busy), int'(e.busy));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("r_valid", int'(r_valid), int'(e.rv));
        got = $signed(d_out);
        chk("d_out", got, e.dout);
      end
    end
  end

  initial begin
    int ua, ud;
    @(negedge clk);
    // Reset then full clear, then every bin reads zero.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    junk(0, DEPTH + 2);
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) rd(c, a);
    // Overwrite then accumulate; other channel unaffected.
    upd(1, 0, 5, 1000);
    upd(0, 0, 5, -300);
    idle(1);
    rd(0, 5);
    upd(1, 1, 5, -7);
    idle(2);
    rd(0, 5);
    rd(1, 5);
    // Back-to-back accumulates to one bin.
    for (int i = 0; i < 4; i++) upd(0, 1, 127, 1);
    idle(1);
    rd(1, 127);
    // Saturation at both rails.
    upd(1, 0, 3, VMAX);
    upd(0, 0, 3, 5);
    idle(1);
    rd(0, 3);
    upd(1, 0, 4, VMIN);
    upd(0, 0, 4, -1);
    idle(1);
    rd(0, 4);
    // Read in the write cycle returns the old value, next cycle the new one.
    upd(1, 0, 9, 10);
    idle(2);
    upd(0, 0, 9, 32);
    rd(0, 9);
    rd(0, 9);
    // Reset during S1 of an update, and again mid-clear.
    upd(1, 0, 20, 55);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    junk(0, 40);
    junk(1, 1);
    junk(0, DEPTH + 1);
    rd(0, 20);
    idle(1);
    // Randomized traffic concentrated on a few bins to exercise forwarding and saturation.
    for (int i = 0; i < 3000; i++) begin
      ua = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: ud = int'($urandom_range(0, 1048575)) - 524288;
        1: ud = ($urandom_range(0, 1) == 1) ? VMAX - int'($urandom_range(0, 3)) : VMIN + int'($urandom_range(0, 3));
        default: ud = int'($urandom_range(0, 400000)) - 200000;
      endcase
      cyc(($urandom_range(0, 1499) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
          int'($urandom_range(0, 1)), ua, ud, 1'($urandom), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)));
    end
    idle(DEPTH + 3);
    #3;
    done = 1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
